// File: rtl/alu_mc.sv
// alu_mc: parametrised datapath ALU with dual-read register bank, flag register,
// address adder, writeback and iterative multiply / variable-shift operations.
module alu_mc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              alu_f,
  input  logic [$clog2(REGS)-1:0] a_idx,
  input  logic [$clog2(REGS)-1:0] b_idx,
  input  logic [$clog2(REGS)-1:0] d_idx,
  input  logic                    wr_reg,
  input  logic                    wr_flags,
  input  logic                    carry_mask,
  input  logic [WIDTH-1:0]        t16,
  input  logic                    sel_inp,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        flags,
  output logic [WIDTH-1:0]        d_val,
  output logic [WIDTH-1:0]        mar_val,
  output logic [WIDTH-1:0]        mem_data,
  output logic                    wr_pc
);

  localparam int unsigned IDX_W = $clog2(REGS);
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DEP  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_ORA  = 4'b0101;
  localparam logic [3:0] OP_EOR  = 4'b0110;
  localparam logic [3:0] OP_LDA  = 4'b0111;
  localparam logic [3:0] OP_EXT  = 4'b1000;
  localparam logic [3:0] OP_BSW  = 4'b1001;
  localparam logic [3:0] OP_LSR  = 4'b1010;
  localparam logic [3:0] OP_ASL  = 4'b1011;
  localparam logic [3:0] OP_MULL = 4'b1100;
  localparam logic [3:0] OP_MULH = 4'b1101;
  localparam logic [3:0] OP_LSRN = 4'b1110;

  localparam logic [IDX_W-1:0] FLAG_IDX = IDX_W'(2);
  localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(3);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  // Pack C, V, Z, N, A into the low bits of a flag word.
  function automatic logic [WIDTH-1:0] status(input logic [WIDTH-1:0] r, input logic c,
                                              input logic v, input logic a);
    return WIDTH'({a, r[MSB], (r == '0), v, c});
  endfunction

  logic [WIDTH-1:0]   regs [REGS];
  logic [WIDTH-1:0]   flags_q;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [3:0]         op_q;
  logic [IDX_W-1:0]   dst_q;
  logic               wr_reg_q, wr_flags_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic               sh_en_q, sh_c_d;
  logic [WIDTH:0]     mul_sum;

  logic [WIDTH-1:0]   a_val, b_val, sel;
  logic               is_sub, cin, multi_op, launch;
  logic [SH_W-1:0]    sh_n;
  logic [CNT_W-1:0]   iters;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res_s, res_m;
  logic               c_s, v_s, af_s, c_m;
  logic [WIDTH-1:0]   stat_s, stat_m;

  logic               wb_en, wb_flags;
  logic [IDX_W-1:0]   wb_idx;
  logic [WIDTH-1:0]   wb_res, wb_stat;

  // Register reads; index 2 aliases the flag register.
  assign a_val    = (a_idx == FLAG_IDX) ? flags_q : regs[a_idx];
  assign b_val    = (b_idx == FLAG_IDX) ? flags_q : regs[b_idx];
  assign sel      = sel_inp ? t16 : b_val;
  assign is_sub   = (alu_f == OP_SUB);
  assign cin      = (flags_q[0] ^ is_sub) & ~carry_mask;
  assign multi_op = (alu_f[3:2] == 2'b11);
  assign launch   = (state_q == ST_IDLE) && start && multi_op;
  assign sh_n     = a_val[SH_W-1:0];
  assign iters    = alu_f[1] ? ((sh_n == '0) ? CNT_W'(1) : CNT_W'(sh_n)) : CNT_W'(WIDTH);

  assign mar_val  = a_val + t16;
  assign mem_data = b_val;
  assign flags    = flags_q;
  assign busy     = (state_q == ST_BUSY);
  assign done     = done_q;

  // Single-cycle operation result and status.
  always_comb begin
    sum   = '0;
    res_s = '0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    af_s  = 1'b0;
    case (alu_f)
      OP_ADD: begin
        sum   = {1'b0, a_val} + {1'b0, sel} + (WIDTH+1)'(cin);
        res_s = sum[WIDTH-1:0];
        c_s   = sum[WIDTH];
        v_s   = (a_val[MSB] == sel[MSB]) && (res_s[MSB] != a_val[MSB]);
      end
      OP_INC: begin
        sum   = {1'b0, b_val} + (WIDTH+1)'(1);
        res_s = sum[WIDTH-1:0];
        c_s   = sum[WIDTH];
        v_s   = ~b_val[MSB] & res_s[MSB];
      end
      OP_SUB: begin
        sum   = {1'b0, a_val} + {1'b0, ~sel} + (WIDTH+1)'(cin);
        res_s = sum[WIDTH-1:0];
        c_s   = sum[WIDTH];
        v_s   = (a_val[MSB] != sel[MSB]) && (res_s[MSB] != a_val[MSB]);
      end
      OP_DEP: begin
        if (b_val != '0) begin
          res_s = b_val - WIDTH'(1);
          af_s  = 1'b1;
          v_s   = b_val[MSB] & ~res_s[MSB];
        end else begin
          res_s = b_val;
        end
      end
      OP_AND: res_s = a_val & sel;
      OP_ORA: res_s = a_val | sel;
      OP_EOR: res_s = a_val ^ sel;
      OP_LDA: res_s = b_val;
      OP_EXT: res_s = WIDTH'($signed(sel[7:0]));
      OP_BSW: res_s = {sel[HALF-1:0], sel[WIDTH-1:HALF]};
      OP_LSR: begin
        res_s = {cin, sel[WIDTH-1:1]};
        c_s   = sel[0];
      end
      OP_ASL: begin
        res_s = {sel[WIDTH-2:0], cin};
        c_s   = sel[MSB];
      end
      default: res_s = '0;
    endcase
    stat_s = status(res_s, c_s, v_s, af_s);
  end

  // One iteration of the multi-cycle datapath: shift-add multiply or 1-bit shift.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
    sh_d    = sh_q;
    sh_c_d  = 1'b0;
    if (sh_en_q) begin
      if (op_q == OP_LSRN) begin
        sh_d   = sh_q >> 1;
        sh_c_d = sh_q[0];
      end else begin
        sh_d   = sh_q << 1;
        sh_c_d = sh_q[MSB];
      end
    end
    case (op_q)
      OP_MULL: begin
        res_m = prod_d[WIDTH-1:0];
        c_m   = (prod_d[2*WIDTH-1:WIDTH] != '0);
      end
      OP_MULH: begin
        res_m = prod_d[2*WIDTH-1:WIDTH];
        c_m   = (prod_d[2*WIDTH-1:WIDTH] != '0);
      end
      default: begin
        res_m = sh_d;
        c_m   = sh_c_d;
      end
    endcase
    stat_m = status(res_m, c_m, 1'b0, 1'b0);
  end

  assign d_val = busy ? res_m : res_s;

  // Writeback source: live single-cycle op in IDLE, latched request in the done cycle.
  always_comb begin
    wb_en    = 1'b0;
    wb_flags = 1'b0;
    wb_idx   = d_idx;
    wb_res   = res_s;
    wb_stat  = stat_s;
    if (state_q == ST_IDLE) begin
      if (!multi_op) begin
        wb_en    = wr_reg;
        wb_flags = wr_flags;
      end
    end else if (done_q) begin
      wb_en    = wr_reg_q;
      wb_flags = wr_flags_q;
      wb_idx   = dst_q;
      wb_res   = res_m;
      wb_stat  = stat_m;
    end
  end

  assign wr_pc = wb_en && (wb_idx == PC_IDX);

  // Next-state logic for the multi-cycle sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_BUSY;
          cnt_d   = iters;
          done_d  = (iters == CNT_W'(1));
        end
      end
      ST_BUSY: begin
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          done_d = (cnt_q == CNT_W'(2));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, operand latches and iteration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      op_q       <= '0;
      dst_q      <= '0;
      wr_reg_q   <= 1'b0;
      wr_flags_q <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
      sh_q       <= '0;
      sh_en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (launch) begin
        op_q       <= alu_f;
        dst_q      <= d_idx;
        wr_reg_q   <= wr_reg;
        wr_flags_q <= wr_flags;
        mcand_q    <= a_val;
        prod_q     <= {WIDTH'(0), sel};
        sh_q       <= sel;
        sh_en_q    <= (sh_n != '0);
      end else if (state_q == ST_BUSY) begin
        prod_q <= prod_d;
        sh_q   <= sh_d;
      end
    end
  end

  // Register bank and flag register; status write beats a raw write to index 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REGS); i++) regs[i] <= '0;
      flags_q <= '0;
    end else begin
      if (wb_en && (wb_idx != FLAG_IDX)) regs[wb_idx] <= wb_res;
      if (wb_flags) flags_q <= wb_stat;
      else if (wb_en && (wb_idx == FLAG_IDX)) flags_q <= wb_res;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: single-cycle vector table plus
// hand-written multi-cycle, abort and wide-parameter sequences.
module tb_alu_mc;

  localparam logic [3:0] ADD = 4'b0000, INC = 4'b0001, SUB = 4'b0010, DEP = 4'b0011;
  localparam logic [3:0] AND = 4'b0100, ORA = 4'b0101, EOR = 4'b0110, LDA = 4'b0111;
  localparam logic [3:0] EXT = 4'b1000, BSW = 4'b1001, LSR = 4'b1010, ASL = 4'b1011;
  localparam logic [3:0] MULL = 4'b1100, MULH = 4'b1101, LSRN = 4'b1110, ASLN = 4'b1111;

  logic        clk, rst;
  logic [3:0]  alu_f;
  logic [2:0]  a_idx, b_idx, d_idx;
  logic        wr_reg, wr_flags, carry_mask, sel_inp, start;
  logic [15:0] t16;
  logic        busy, done, wr_pc;
  logic [15:0] flags, d_val, mar_val, mem_data;

  logic [3:0]  w_alu_f;
  logic [3:0]  w_a_idx, w_b_idx, w_d_idx;
  logic        w_wr_reg, w_wr_flags, w_carry_mask, w_sel_inp, w_start;
  logic [31:0] w_t16;
  logic        w_busy, w_done, w_wr_pc;
  logic [31:0] w_flags, w_d_val, w_mar_val, w_mem_data;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(16), .REGS(8)) u_dut (
    .clk(clk), .rst(rst), .alu_f(alu_f), .a_idx(a_idx), .b_idx(b_idx), .d_idx(d_idx),
    .wr_reg(wr_reg), .wr_flags(wr_flags), .carry_mask(carry_mask), .t16(t16),
    .sel_inp(sel_inp), .start(start), .busy(busy), .done(done), .flags(flags),
    .d_val(d_val), .mar_val(mar_val), .mem_data(mem_data), .wr_pc(wr_pc)
  );

  alu_mc #(.WIDTH(32), .REGS(16)) u_dut32 (
    .clk(clk), .rst(rst), .alu_f(w_alu_f), .a_idx(w_a_idx), .b_idx(w_b_idx), .d_idx(w_d_idx),
    .wr_reg(w_wr_reg), .wr_flags(w_wr_flags), .carry_mask(w_carry_mask), .t16(w_t16),
    .sel_inp(w_sel_inp), .start(w_start), .busy(w_busy), .done(w_done), .flags(w_flags),
    .d_val(w_d_val), .mar_val(w_mar_val), .mem_data(w_mem_data), .wr_pc(w_wr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [2:0]  a, b, d;
    logic        wr, wf, cm, si;
    logic [15:0] t;
    logic [15:0] exp_d;
    logic        exp_pc;
    logic [15:0] exp_fl;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] d, input logic wr, input logic wf,
                              input logic cm, input logic si, input logic [15:0] t,
                              input logic [15:0] ed, input logic epc, input logic [15:0] efl);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.d = d; v.wr = wr; v.wf = wf; v.cm = cm; v.si = si;
    v.t = t; v.exp_d = ed; v.exp_pc = epc; v.exp_fl = efl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_f = LDA; a_idx = '0; b_idx = '0; d_idx = '0; wr_reg = 1'b0; wr_flags = 1'b0;
    carry_mask = 1'b0; sel_inp = 1'b0; start = 1'b0; t16 = '0;
  endtask

  task automatic load(input logic [2:0] idx, input logic [15:0] val);
    alu_f = ADD; a_idx = 3'd0; sel_inp = 1'b1; t16 = val; carry_mask = 1'b1;
    wr_reg = 1'b1; wr_flags = 1'b0; d_idx = idx; start = 1'b0;
    step();
    idle_inputs();
  endtask

  task automatic run_mc(input string nm, input logic [3:0] op, input logic [2:0] a,
                        input logic [15:0] t, input logic [2:0] d, input int lat,
                        input logic [15:0] res, input logic [15:0] fl, input logic pc);
    int got;
    logic busy_ok;
    logic [15:0] dv;
    logic pcv;
    got = 0; busy_ok = 1'b1; dv = '0; pcv = 1'b0;
    alu_f = op; a_idx = a; sel_inp = 1'b1; t16 = t; d_idx = d;
    wr_reg = 1'b1; wr_flags = 1'b1; carry_mask = 1'b0; start = 1'b1;
    #1;
    chk({nm, "_pc_at_start"}, 32'(wr_pc), 32'd0);
    step();
    for (int k = 1; k <= 40; k++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        got = k; dv = d_val; pcv = wr_pc;
        break;
      end
      start = (k == 2);
      alu_f = (k == 2) ? MULL : LDA;
      b_idx = 3'd0; wr_reg = 1'b1; wr_flags = 1'b1; d_idx = 3'd6;
      step();
    end
    idle_inputs();
    chk({nm, "_latency"}, 32'(got), 32'(lat));
    chk({nm, "_busy"}, 32'(busy_ok), 32'd1);
    chk({nm, "_d_val"}, 32'(dv), 32'(res));
    chk({nm, "_wr_pc"}, 32'(pcv), 32'(pc));
    step();
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_done_after"}, 32'(done), 32'd0);
    b_idx = d;
    #1;
    chk({nm, "_reg"}, 32'(mem_data), 32'(res));
    chk({nm, "_flags"}, 32'(flags), 32'(fl));
  endtask

  initial begin
    int seen_done;
    vt[0]  = mk(ADD, 3'd0, 3'd0, 3'd1, 1, 0, 1, 1, 16'h7FFF, 16'h7FFF, 0, 16'h0000);
    vt[1]  = mk(ADD, 3'd1, 3'd0, 3'd4, 1, 1, 1, 1, 16'h0001, 16'h8000, 0, 16'h000A);
    vt[2]  = mk(ADD, 3'd0, 3'd0, 3'd5, 1, 0, 1, 1, 16'h00F0, 16'h00F0, 0, 16'h000A);
    vt[3]  = mk(SUB, 3'd4, 3'd5, 3'd6, 1, 1, 0, 0, 16'h0000, 16'h7F10, 0, 16'h0003);
    vt[4]  = mk(ADD, 3'd5, 3'd0, 3'd7, 1, 1, 0, 1, 16'h000F, 16'h0100, 0, 16'h0000);
    vt[5]  = mk(INC, 3'd0, 3'd1, 3'd0, 0, 1, 0, 0, 16'h0000, 16'h8000, 0, 16'h000A);
    vt[6]  = mk(DEP, 3'd0, 3'd0, 3'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0004);
    vt[7]  = mk(DEP, 3'd0, 3'd5, 3'd0, 0, 1, 0, 0, 16'h0000, 16'h00EF, 0, 16'h0010);
    vt[8]  = mk(AND, 3'd5, 3'd0, 3'd0, 0, 1, 0, 1, 16'h0F3C, 16'h0030, 0, 16'h0000);
    vt[9]  = mk(ORA, 3'd5, 3'd0, 3'd0, 0, 1, 0, 1, 16'hF00F, 16'hF0FF, 0, 16'h0008);
    vt[10] = mk(EOR, 3'd5, 3'd0, 3'd0, 0, 1, 0, 1, 16'h00F0, 16'h0000, 0, 16'h0004);
    vt[11] = mk(EXT, 3'd0, 3'd0, 3'd0, 0, 1, 0, 1, 16'h1280, 16'hFF80, 0, 16'h0008);
    vt[12] = mk(EXT, 3'd0, 3'd0, 3'd0, 0, 1, 0, 1, 16'hAB7F, 16'h007F, 0, 16'h0000);
    vt[13] = mk(BSW, 3'd0, 3'd0, 3'd0, 0, 1, 0, 1, 16'h12AB, 16'hAB12, 0, 16'h0008);
    vt[14] = mk(LSR, 3'd0, 3'd0, 3'd0, 0, 1, 0, 1, 16'h8001, 16'h4000, 0, 16'h0001);
    vt[15] = mk(LSR, 3'd0, 3'd0, 3'd0, 0, 1, 0, 1, 16'h0002, 16'h8001, 0, 16'h0008);
    vt[16] = mk(ASL, 3'd0, 3'd0, 3'd0, 0, 1, 1, 1, 16'h8001, 16'h0002, 0, 16'h0001);
    vt[17] = mk(ASL, 3'd0, 3'd0, 3'd0, 0, 1, 0, 1, 16'h4000, 16'h8001, 0, 16'h0008);
    vt[18] = mk(ADD, 3'd0, 3'd0, 3'd7, 1, 0, 1, 1, 16'hFFFF, 16'hFFFF, 0, 16'h0008);
    vt[19] = mk(LDA, 3'd0, 3'd7, 3'd2, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 16'hFFFF);
    vt[20] = mk(LDA, 3'd0, 3'd2, 3'd3, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 1, 16'hFFFF);
    vt[21] = mk(LDA, 3'd0, 3'd3, 3'd3, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 16'hFFFF);
    vt[22] = mk(LDA, 3'd0, 3'd0, 3'd2, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0004);

    idle_inputs();
    w_alu_f = LDA; w_a_idx = '0; w_b_idx = '0; w_d_idx = '0; w_wr_reg = 1'b0;
    w_wr_flags = 1'b0; w_carry_mask = 1'b0; w_sel_inp = 1'b0; w_start = 1'b0; w_t16 = '0;

    // Reset: one cycle, then every register and status output reads zero.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_idx = 3'(i);
      #1;
      chk($sformatf("reset_r%0d", i), 32'(mem_data), 32'd0);
    end
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_w_busy", 32'(w_busy), 32'd0);
    chk("reset_w_done", 32'(w_done), 32'd0);
    chk("reset_w_flags", w_flags, 32'd0);

    // Single-cycle vector table.
    for (int i = 0; i < 23; i++) begin
      alu_f = vt[i].f; a_idx = vt[i].a; b_idx = vt[i].b; d_idx = vt[i].d;
      wr_reg = vt[i].wr; wr_flags = vt[i].wf; carry_mask = vt[i].cm;
      sel_inp = vt[i].si; t16 = vt[i].t; start = 1'b0;
      #1;
      chk($sformatf("vec%0d_d_val", i), 32'(d_val), 32'(vt[i].exp_d));
      chk($sformatf("vec%0d_wr_pc", i), 32'(wr_pc), 32'(vt[i].exp_pc));
      step();
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vt[i].exp_fl));
    end
    idle_inputs();
    b_idx = 3'd4;
    #1;
    chk("read_r4", 32'(mem_data), 32'h8000);
    b_idx = 3'd3;
    #1;
    chk("read_r3", 32'(mem_data), 32'hFFFF);
    a_idx = 3'd1; t16 = 16'h8002;
    #1;
    chk("mar_wrap", 32'(mar_val), 32'h0001);
    idle_inputs();

    // Multi-cycle sequences.
    load(3'd1, 16'h1234);
    load(3'd4, 16'h0004);
    load(3'd5, 16'h0003);
    run_mc("mull",       MULL, 3'd1, 16'h0100, 3'd3, 16, 16'h3400, 16'h0001, 1'b1);
    run_mc("mulh",       MULH, 3'd1, 16'h0100, 3'd7, 16, 16'h0012, 16'h0001, 1'b0);
    run_mc("mull_ffff",  MULL, 3'd1, 16'hFFFF, 3'd7, 16, 16'hEDCC, 16'h0009, 1'b0);
    run_mc("mulh_ffff",  MULH, 3'd1, 16'hFFFF, 3'd7, 16, 16'h1233, 16'h0001, 1'b0);
    run_mc("asln4",      ASLN, 3'd4, 16'h8421, 3'd7, 4,  16'h4210, 16'h0000, 1'b0);
    run_mc("asln0",      ASLN, 3'd0, 16'h8421, 3'd7, 1,  16'h8421, 16'h0008, 1'b0);
    run_mc("lsrn3",      LSRN, 3'd5, 16'h0085, 3'd7, 3,  16'h0010, 16'h0001, 1'b0);
    run_mc("lsrn_low4",  LSRN, 3'd1, 16'hF0F0, 3'd7, 4,  16'h0F0F, 16'h0000, 1'b0);
    b_idx = 3'd6;
    #1;
    chk("busy_writes_ignored", 32'(mem_data), 32'h7F10);

    // Abort: reset in the fifth busy cycle of a multiply.
    alu_f = MULL; a_idx = 3'd1; sel_inp = 1'b1; t16 = 16'h0100; d_idx = 3'd3;
    wr_reg = 1'b1; wr_flags = 1'b1; start = 1'b1;
    step();
    idle_inputs();
    for (int k = 1; k < 5; k++) step();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 24; k++) begin
      if (done === 1'b1) seen_done = 1;
      step();
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    b_idx = 3'd3;
    #1;
    chk("abort_dest", 32'(mem_data), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);

    // Wide instance: full-width half swap.
    w_alu_f = BSW; w_sel_inp = 1'b1; w_t16 = 32'h12345678; w_wr_reg = 1'b1; w_d_idx = 4'd15;
    #1;
    chk("w_bsw_d_val", w_d_val, 32'h56781234);
    chk("w_mar_val", w_mar_val, 32'h12345678);
    chk("w_wr_pc", 32'(w_wr_pc), 32'd0);
    step();
    w_wr_reg = 1'b0; w_b_idx = 4'd15;
    #1;
    chk("w_bsw_reg", w_mem_data, 32'h56781234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
